// File: rtl/tick_gen_pkg.sv
// Shared definitions for the multi-channel tick generator.
// Optional square-wave outputs are enabled with the TICK_GEN_SQUARE_EN macro.
package tick_gen_pkg;

   // Period loaded into every channel when no other value is supplied.
   localparam int RESET_TOP_DEFAULT = 12000;

   // Width of a channel index; a single channel still gets a 1-bit index.
   function automatic int chan_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tick_chan.sv
// One tick channel: wrap counter, period register and registered strobe.
// A pending period is taken at the next wrap, or immediately while disabled.
// The toggle output sq_o exists only with TICK_GEN_SQUARE_EN defined.
module tick_chan
   import tick_gen_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int RESET_TOP = RESET_TOP_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             pend_i,
   input  logic [WIDTH-1:0] val_i,
   output logic             apply_o,
   output logic             tick_o
`ifdef TICK_GEN_SQUARE_EN
   ,
   output logic             sq_o
`endif
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] top_q, top_d;
   logic             tick_q, tick_d;
   logic             wrap;

   assign wrap    = en_i && (cnt_q == top_q);
   // A pending period lands on a wrap edge or on any disabled edge.
   assign apply_o = pend_i && (wrap || !en_i);
   assign tick_o  = tick_q;

   // Next-state: count enabled cycles, strobe on wrap, take new period on apply.
   always_comb begin
      cnt_d  = cnt_q;
      top_d  = top_q;
      tick_d = 1'b0;
      if (en_i) begin
         if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      if (apply_o) begin
         top_d = val_i;
         cnt_d = '0;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         top_q  <= WIDTH'(RESET_TOP);
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         top_q  <= top_d;
         tick_q <= tick_d;
      end
   end

`ifdef TICK_GEN_SQUARE_EN
   logic sq_q;

   assign sq_o = sq_q;

   // Square wave flips together with every strobe, so it holds while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sq_q <= 1'b0;
      end else if (tick_d) begin
         sq_q <= ~sq_q;
      end
   end
`endif

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator with a one-deep period-load slot.
// Square-wave outputs (port sq) are present only with TICK_GEN_SQUARE_EN defined.
module tick_gen
   import tick_gen_pkg::*;
#(
   parameter int CHANNELS  = 2,
   parameter int WIDTH     = 32,
   parameter int RESET_TOP = RESET_TOP_DEFAULT
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [CHANNELS-1:0]           en,
   input  logic                          load_valid,
   input  logic [chan_w(CHANNELS)-1:0]   load_chan,
   input  logic [WIDTH-1:0]              load_top,
   output logic                          load_ready,
   output logic [CHANNELS-1:0]           tick
`ifdef TICK_GEN_SQUARE_EN
   ,
   output logic [CHANNELS-1:0]           sq
`endif
);

   localparam int CW = chan_w(CHANNELS);

   typedef logic [CW-1:0] chan_idx_t;

   logic          busy_q, busy_d;
   chan_idx_t     chan_q, chan_d;
   logic [WIDTH-1:0] val_q, val_d;
   logic          chan_ok;
   logic [CHANNELS-1:0] pend;
   logic [CHANNELS-1:0] applied;

   // Indices beyond the last channel are accepted and then dropped.
   assign chan_ok    = ({1'b0, chan_q} < (CW+1)'(CHANNELS));
   assign load_ready = !busy_q;

   // Slot next-state: capture when idle, release once applied or discarded.
   always_comb begin
      busy_d = busy_q;
      chan_d = chan_q;
      val_d  = val_q;
      if (busy_q) begin
         if (!chan_ok || (|applied)) begin
            busy_d = 1'b0;
         end
      end else if (load_valid) begin
         busy_d = 1'b1;
         chan_d = load_chan;
         val_d  = load_top;
      end
   end

   // Busy flag is the only slot state that needs a reset value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Slot payload is only meaningful while busy is set.
   always_ff @(posedge clk) begin
      chan_q <= chan_d;
      val_q  <= val_d;
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      assign pend[g] = busy_q && ({1'b0, chan_q} == (CW+1)'(g));
`ifdef TICK_GEN_SQUARE_EN
      tick_chan #(
         .WIDTH     (WIDTH),
         .RESET_TOP (RESET_TOP)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .en_i    (en[g]),
         .pend_i  (pend[g]),
         .val_i   (val_q),
         .apply_o (applied[g]),
         .tick_o  (tick[g]),
         .sq_o    (sq[g])
      );
`else
      tick_chan #(
         .WIDTH     (WIDTH),
         .RESET_TOP (RESET_TOP)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .en_i    (en[g]),
         .pend_i  (pend[g]),
         .val_i   (val_q),
         .apply_o (applied[g]),
         .tick_o  (tick[g])
      );
`endif
   end

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: reset vector table, directed corner
// sequences and randomized traffic against a period-counting reference model.
module tb_tick_gen;

   localparam int CH = 3;
   localparam int W  = 8;
   localparam int RT = 4;
   localparam int CW = 2;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [CH-1:0] en    = '0;
   logic          lv    = 1'b0;
   logic [CW-1:0] lc    = '0;
   logic [W-1:0]  lt    = '0;
   wire           ready;
   wire  [CH-1:0] tick;
`ifdef TICK_GEN_SQUARE_EN
   wire  [CH-1:0] sq;
`endif

   tick_gen #(
      .CHANNELS  (CH),
      .WIDTH     (W),
      .RESET_TOP (RT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .load_valid (lv),
      .load_chan  (lc),
      .load_top   (lt),
      .load_ready (ready),
      .tick       (tick)
`ifdef TICK_GEN_SQUARE_EN
      ,
      .sq         (sq)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: each channel counts enabled cycles elapsed in its
   // current period; a period of length per+1 completes with a strobe.
   int            m_per [CH];
   int            m_el  [CH];
   logic [CH-1:0] m_tick;
   logic [CH-1:0] m_sq;
   bit            m_pend;
   int            m_pc;
   int            m_pv;
   bit            m_acc;

   function automatic void m_reset();
      for (int i = 0; i < CH; i++) begin
         m_per[i] = RT;
         m_el[i]  = 0;
      end
      m_tick = '0;
      m_sq   = '0;
      m_pend = 0;
      m_acc  = 0;
   endfunction

   function automatic void m_edge();
      bit done = 0;
      bit ready_before = !m_pend;
      for (int i = 0; i < CH; i++) begin
         if (en[i]) begin
            m_el[i] = m_el[i] + 1;
            if (m_el[i] == m_per[i] + 1) begin
               m_tick[i] = 1'b1;
               m_sq[i]   = ~m_sq[i];
               m_el[i]   = 0;
               if (m_pend && m_pc == i) begin
                  m_per[i] = m_pv;
                  done = 1;
               end
            end else begin
               m_tick[i] = 1'b0;
            end
         end else begin
            m_tick[i] = 1'b0;
            if (m_pend && m_pc == i) begin
               m_per[i] = m_pv;
               m_el[i]  = 0;
               done = 1;
            end
         end
      end
      if (m_pend && m_pc >= CH) done = 1;
      if (done) m_pend = 0;
      m_acc = lv && ready_before;
      if (m_acc) begin
         m_pend = 1;
         m_pc   = int'(lc);
         m_pv   = int'(lt);
      end
   endfunction

   function automatic void chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endfunction

   task automatic compare_model();
      chk("tick", int'(tick), int'(m_tick));
      chk("load_ready", int'(ready), int'(!m_pend));
`ifdef TICK_GEN_SQUARE_EN
      chk("sq", int'(sq), int'(m_sq));
`endif
   endtask

   task automatic step();
      @(posedge clk);
      m_edge();
      #1;
      compare_model();
   endtask

   task automatic do_load(input int c, input int v);
      lv = 1'b1;
      lc = CW'(c);
      lt = W'(v);
      for (int k = 0; k < 64; k++) begin
         step();
         if (m_acc) break;
      end
      if (!m_acc) chk("load_accept_timeout", 0, 1);
      lv = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && m_pend; k++) step();
      if (m_pend) chk("drain_timeout", 0, 1);
   endtask

   typedef struct {
      logic [CH-1:0] en;
      logic [CH-1:0] tick;
      logic          ready;
   } vec_t;

   vec_t tbl [16];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 16; k++) begin
         tbl[k].en    = '1;
         tbl[k].tick  = (((k + 1) % (RT + 1)) == 0) ? '1 : '0;
         tbl[k].ready = 1'b1;
      end

      m_reset();
      #2;
      chk("rst_tick", int'(tick), 0);
      chk("rst_ready", int'(ready), 1);
`ifdef TICK_GEN_SQUARE_EN
      chk("rst_sq", int'(sq), 0);
`endif

      // Default period straight out of reset.
      @(negedge clk);
      en    = '1;
      rst_n = 1'b1;
      for (int k = 0; k < 16; k++) begin
         en = tbl[k].en;
         step();
         chk("tbl_tick", int'(tick), int'(tbl[k].tick));
         chk("tbl_ready", int'(ready), int'(tbl[k].ready));
      end

      // Enable gating on channel 0 with a period of 4.
      do_load(0, 3);
      drain();
      repeat (5) step();
      en[0] = 1'b0;
      repeat (2) step();
      en[0] = 1'b1;
      repeat (12) step();

      // Load applied at a wrap on channel 1.
      do_load(1, 9);
      drain();
      repeat (2) step();
      do_load(1, 2);
      chk("wrap_ready_low", int'(ready), 0);
      drain();
      repeat (8) step();

      // Disabled apply on channel 0.
      en[0] = 1'b0;
      do_load(0, 2);
      chk("dis_ready_low", int'(ready), 0);
      step();
      chk("dis_ready_back", int'(ready), 1);
      en[0] = 1'b1;
      step();
      chk("dis_tick_e1", int'(tick[0]), 0);
      step();
      chk("dis_tick_e2", int'(tick[0]), 0);
      step();
      chk("dis_tick_e3", int'(tick[0]), 1);

      // Out-of-range channel is swallowed in one cycle.
      do_load(3, 5);
      chk("bad_ready_low", int'(ready), 0);
      step();
      chk("bad_ready_back", int'(ready), 1);

      // Period of one cycle on channel 2.
      do_load(2, 0);
      drain();
      for (int k = 0; k < 6; k++) begin
`ifdef TICK_GEN_SQUARE_EN
         logic prev_sq;
         prev_sq = sq[2];
`endif
         step();
         chk("top0_tick", int'(tick[2]), 1);
`ifdef TICK_GEN_SQUARE_EN
         chk("top0_sq_toggle", int'(sq[2]), int'(~prev_sq));
`endif
      end

      // Randomized enables and loads, requester holds until accepted.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < CH; i++) en[i] = ($urandom_range(0, 9) < 8);
         if (!lv && $urandom_range(0, 5) == 0) begin
            lv = 1'b1;
            lc = CW'($urandom_range(0, 3));
            lt = W'($urandom_range(0, 6));
         end
         step();
         if (m_acc) lv = 1'b0;
      end
      lv = 1'b0;
      en = '1;
      drain();

      // Reset while a load is pending on channel 1.
      en[1] = 1'b0;
      do_load(1, 200);
      drain();
      en[1] = 1'b1;
      do_load(1, 7);
      repeat (3) step();
      chk("pend_before_rst", int'(ready), 0);
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      chk("midrst_tick", int'(tick), 0);
      chk("midrst_ready", int'(ready), 1);
`ifdef TICK_GEN_SQUARE_EN
      chk("midrst_sq", int'(sq), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
